// File: rtl/lsu_ctrl.sv
// Load/store control unit: latches one RV32I load/store request, drives the data memory for a
// single ACCESS cycle, then holds an extended, registered response until it is consumed.
module lsu_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [3:0]               mem_WE,
  output logic [2:0]               mem_RE,
  output logic [7:0]               mem_WD1,
  output logic [7:0]               mem_WD2,
  output logic [7:0]               mem_WD3,
  output logic [7:0]               mem_WD4,
  input  logic [DATA_WIDTH-1:0]    mem_RD,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;

  logic                     err;
  logic                     bad_code;
  logic [DATA_WIDTH-1:0]    load_data;

  // Illegal size codes differ for loads and stores; alignment rules are shared.
  always_comb begin
    bad_code = 1'b0;
    if (we_q) begin
      bad_code = funct3_q[2] | (funct3_q[1:0] == 2'b11);
    end else begin
      bad_code = (funct3_q == 3'b011) | (funct3_q[2:1] == 2'b11);
    end
    err = bad_code
        | ((funct3_q[1:0] == 2'b01) & addr_q[0])
        | ((funct3_q == 3'b010) & (addr_q[1:0] != 2'b00));
  end

  always_comb begin
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){mem_RD[7]}}, mem_RD[7:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, mem_RD[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){mem_RD[15]}}, mem_RD[15:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, mem_RD[15:0]};
      3'b010:  load_data = mem_RD;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_WE     = 4'b0000;
    mem_RE     = 3'b111;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StAccess;
      end
      StAccess: begin
        state_d = StResp;
        if (we_q && !err) begin
          case (funct3_q)
            3'b000:  mem_WE = 4'b0001;
            3'b001:  mem_WE = 4'b0011;
            3'b010:  mem_WE = 4'b1111;
            default: mem_WE = 4'b0000;
          endcase
        end
        if (!we_q && (funct3_q[1:0] == 2'b00)) mem_RE = 3'b000;
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == StAccess) begin
        rdata_q <= (we_q || err) ? '0 : load_data;
        err_q   <= err;
      end
    end
  end

  assign mem_A      = addr_q;
  assign mem_WD1    = wdata_q[7:0];
  assign mem_WD2    = wdata_q[15:8];
  assign mem_WD3    = wdata_q[23:16];
  assign mem_WD4    = wdata_q[31:24];
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table through full transactions, plus stall, no-bypass
// and mid-access reset sequences against a small byte-addressed memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] mem_A;
  logic [3:0]  mem_WE;
  logic [2:0]  mem_RE;
  logic [7:0]  mem_WD1, mem_WD2, mem_WD3, mem_WD4;
  logic [31:0] mem_RD = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:1023];

  lsu_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_A      (mem_A),
    .mem_WE     (mem_WE),
    .mem_RE     (mem_RE),
    .mem_WD1    (mem_WD1),
    .mem_WD2    (mem_WD2),
    .mem_WD3    (mem_WD3),
    .mem_WD4    (mem_WD4),
    .mem_RD     (mem_RD),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // Memory model: byte write per enable bit at the rising edge.
  always @(posedge clk) begin
    if (mem_WE[0]) mem[mem_A[9:0]]          <= mem_WD1;
    if (mem_WE[1]) mem[mem_A[9:0] + 10'd1]  <= mem_WD2;
    if (mem_WE[2]) mem[mem_A[9:0] + 10'd2]  <= mem_WD3;
    if (mem_WE[3]) mem[mem_A[9:0] + 10'd3]  <= mem_WD4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  exp_we;
    logic [2:0]  exp_re;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_RD     = v.rd;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk($sformatf("v%0d_acc_ready", i), 32'(req_ready), 32'd0);
    chk($sformatf("v%0d_acc_we", i), 32'(mem_WE), 32'(v.exp_we));
    chk($sformatf("v%0d_acc_re", i), 32'(mem_RE), 32'(v.exp_re));
    chk($sformatf("v%0d_acc_a", i), mem_A, v.addr);
    chk($sformatf("v%0d_acc_wd", i), {mem_WD4, mem_WD3, mem_WD2, mem_WD1}, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
    chk($sformatf("v%0d_resp_we", i), 32'(mem_WE), 32'd0);
    chk($sformatf("v%0d_resp_re", i), 32'(mem_RE), 32'(3'b111));
    chk($sformatf("v%0d_rdata", i), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(v.exp_err));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk($sformatf("v%0d_done_ready", i), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d_done_valid", i), 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we    f3      addr        wdata         rd            WE       RE      rdata         err
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 3'b111, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00000080, 4'b0000, 3'b000, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h00000080, 4'b0000, 3'b000, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h12348001, 4'b0000, 3'b111, 32'hFFFF8001, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h12348001, 4'b0000, 3'b111, 32'h00008001, 1'b0};
    vecs[5]  = '{1'b1, 3'b010, 32'h103, 32'h01020304, 32'h0,        4'b0000, 3'b111, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 3'b000, 32'h203, 32'h000000AA, 32'h0,        4'b0001, 3'b111, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0,        4'b0011, 3'b111, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 4'b0000, 3'b111, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h12348001, 4'b0000, 3'b111, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h12345678, 4'b0000, 3'b111, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h55555555, 32'h0,        4'b0000, 3'b111, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h87654321, 4'b0000, 3'b111, 32'h0,        1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);

    // Reset state, asserted asynchronously before any clock edge
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_we", 32'(mem_WE), 32'd0);
    chk("rst_re", 32'(mem_RE), 32'(3'b111));
    chk("rst_a", mem_A, 32'd0);
    chk("rst_wd", {mem_WD4, mem_WD3, mem_WD2, mem_WD1}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    chk("mem_100", 32'(mem[10'h100]), 32'hEF);
    chk("mem_101", 32'(mem[10'h101]), 32'hBE);
    chk("mem_102", 32'(mem[10'h102]), 32'hAD);
    chk("mem_103", 32'(mem[10'h103]), 32'hDE);
    chk("mem_104_mis", 32'(mem[10'h104]), 32'(init_byte(32'h104)));
    chk("mem_105_mis", 32'(mem[10'h105]), 32'(init_byte(32'h105)));
    chk("mem_106_mis", 32'(mem[10'h106]), 32'(init_byte(32'h106)));
    chk("mem_202", 32'(mem[10'h202]), 32'h34);
    chk("mem_203", 32'(mem[10'h203]), 32'h12);

    // Response stall with a competing request, then no-bypass on the handshake edge
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h104; req_wdata = '0; mem_RD = 32'h11223344;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    mem_RD = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("stall%0d_rdata", c), resp_rdata, 32'h11223344);
      chk($sformatf("stall%0d_err", c), 32'(resp_err), 32'd0);
      chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("stall%0d_we", c), 32'(mem_WE), 32'd0);
      @(posedge clk); #1;
    end
    chk("stall_end_valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("nobypass_ready", 32'(req_ready), 32'd1);
    chk("nobypass_we", 32'(mem_WE), 32'd0);
    chk("nobypass_valid", 32'(resp_valid), 32'd0);
    // resp_ready stays high through ACCESS; it must not skip the response
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("next_acc_we", 32'(mem_WE), 32'(4'b1111));
    chk("next_acc_a", mem_A, 32'h300);
    chk("next_acc_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("next_resp_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("next_done_ready", 32'(req_ready), 32'd1);
    chk("mem_300", 32'(mem[10'h300]), 32'hD4);

    // Reset pulsed in the middle of a store's ACCESS cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_acc_we", 32'(mem_WE), 32'(4'b1111));
    #1;
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(mem_WE), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_a", mem_A, 32'd0);
    @(posedge clk); #1;
    chk("abort_hold_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_200", 32'(mem[10'h200]), 32'(init_byte(32'h200)));
    chk("abort_mem_201", 32'(mem[10'h201]), 32'(init_byte(32'h201)));
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Accept immediately after reset release
    run_vec(100, vecs[8]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, 32, byte-address width; DATA_WIDTH, 32, load/store data width.
REQ-002 SHALL have port: clk  in  1  single clock; all sequential logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  load/store request present.
REQ-005 SHALL have port: req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port: req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: req_addr  in  ADDRESS_WIDTH  byte address.
REQ-009 SHALL have port: req_wdata  in  DATA_WIDTH  store data, valid bits aligned at bit 0.
REQ-010 SHALL have port: mem_A  out  ADDRESS_WIDTH  data-memory byte address.
REQ-011 SHALL have port: mem_WE  out  4  per-byte write enables; bit i writes byte A+i.
REQ-012 SHALL have port: mem_RE  out  3  read mode: 000 = zero-extended byte, 111 = word.
REQ-013 SHALL have ports: mem_WD1, mem_WD2, mem_WD3, mem_WD4  out  8 each  write bytes for A, A+1, A+2, A+3.
REQ-014 SHALL have port: mem_RD  in  DATA_WIDTH  combinational read data from memory.
REQ-015 SHALL have port: resp_valid  out  1  response available.
REQ-016 SHALL have port: resp_ready  in  1  consumer accepts response.
REQ-017 SHALL have port: resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-018 SHALL have port: resp_err  out  1  misaligned address or illegal funct3.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS, and RESP.
REQ-020 In IDLE, req_ready SHALL be 1; req_valid=1 at a rising edge SHALL latch req_we, req_funct3, req_addr, and req_wdata into request registers and move to ACCESS.
REQ-021 In ACCESS and RESP, req_ready SHALL be 0, and req_valid SHALL be ignored.
REQ-022 Error detection: err SHALL be 1 when any of the following holds: H/HU with addr[0]=1; W with addr[1:0]≠00; load funct3 ∈ {011, 110, 111}; store funct3 ∉ {000, 001, 010}.
REQ-023 ACCESS SHALL last exactly one cycle, with mem_A = latched address.
REQ-024 For a store in ACCESS with err=0, mem_WE SHALL be SB 0001, SH 0011, or SW 1111.
REQ-025 mem_WD1..mem_WD4 SHALL equal wdata[7:0], [15:8], [23:16], [31:24] at all times.
REQ-026 For a load in ACCESS, mem_RE SHALL be 000 for B/BU and 111 for all other codes.
REQ-027 At the end of ACCESS, a load SHALL register resp_rdata as follows: B sign-extends RD[7:0]; BU zero-extends RD[7:0]; H sign-extends RD[15:0]; HU zero-extends RD[15:0]; W takes RD[31:0].
REQ-028 On the ACCESS-to-RESP edge, resp_err SHALL be registered; err=1 SHALL force mem_WE=0000 in ACCESS and resp_rdata=0.
REQ-029 mem_WE SHALL be 0000 in every state other than ACCESS.
REQ-030 mem_RE SHALL be 111 outside a load ACCESS, and mem_A SHALL hold the latched address.
REQ-031 In RESP, resp_valid SHALL be 1 while resp_rdata and resp_err stay stable; resp_ready=1 at an edge SHALL move the FSM to IDLE.
REQ-032 Latency: a request accepted at edge E0 SHALL cause the memory write at E1, with resp_valid high from E1 until the handshake; minimum request-to-next-accept time SHALL be 3 edges.
REQ-033 resp_ready=1 while not in RESP SHALL have no effect.
REQ-034 The unit SHALL hold no bypass path: a new request is never accepted in the cycle RESP completes.

Reset
REQ-035 rst=1 SHALL immediately, without waiting for clk, force: state IDLE; request registers 0; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_WE=0000; mem_A=0; mem_RE=111; mem_WD1..mem_WD4=0.
REQ-036 If rst is asserted during ACCESS, mem_WE SHALL drop to 0000 before the next edge, the store SHALL be aborted, and no response SHALL be produced.
REQ-037 On the first edge after rst deasserts, the FSM SHALL be in IDLE and able to accept.

Verification
REQ-038 The bench SHALL cover SW, addr 0x100, wdata 0xDEADBEEF: in ACCESS, WE=1111, A=0x100, WD1..4=EF/BE/AD/DE; then resp_valid=1, err=0, rdata=0.
REQ-039 The bench SHALL cover LB at 0x101 with mem_RD=0x00000080: in ACCESS, RE=000; rdata=0xFFFFFF80; the same access as LBU gives 0x00000080.
REQ-040 The bench SHALL cover LH at 0x102 with mem_RD=0x12348001: rdata=0xFFFF8001; LHU gives 0x00008001; RE=111.
REQ-041 The bench SHALL cover SW at 0x103: WE stays 0000 in all cycles, resp_err=1, rdata=0; memory contents are unchanged.
REQ-042 The bench SHALL cover resp_ready held low for 3 cycles after a load: resp_valid, rdata, and err stay stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-043 The bench SHALL cover rst pulsed mid-ACCESS of SW 0x200: WE drops to 0 asynchronously, resp_valid=0, req_ready=1, and the memory byte at 0x200 is unchanged.
